axis_frame_receiver: RTL and testbench
======================================

Name: axis_frame_receiver

Overview:
- AXI4-Stream slave that consumes the 32-bit word stream produced by the crypto engine's master port and reassembles it into parallel fields for the PS-side result buffer.
- In encryption mode a frame is 28 words: 8 words public key, 2 words nonce, 2 words counter, 16 words payload, MSB word first, with tlast on word 27.
- In decryption mode a frame is the 16-word payload only.
- Checks framing, holds each good frame until the consumer accepts it, and counts good and bad frames.

Parameters:
- HDR_WORDS, 12, header words in encryption mode (key 8 + nonce 2 + counter 2).
- PAY_WORDS, 16, payload words per frame (512 bits).
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- axis_clk  in  1  clock.
- axis_reset_n  in  1  asynchronous active-low reset.
- encryp_decryp  in  1  0 = encryption framing (header + payload), 1 = decryption framing (payload only). Sampled on the first accepted word of a frame.
- s_axis_valid  in  1  stream word valid.
- s_axis_data  in  32  stream word, MSB word of each field first.
- s_axis_last  in  1  end-of-frame marker.
- s_axis_ready  out  1  receiver can accept a word.
- frame_valid  out  1  reassembled frame available.
- frame_ready  in  1  consumer accepts the frame.
- frame_key  out  256  public key (0 in decryption mode).
- frame_nonce  out  64  nonce (0 in decryption mode).
- frame_counter  out  64  block counter (0 in decryption mode).
- frame_data  out  512  payload.
- frame_err  out  1  one-cycle pulse on a framing error.
- good_count  out  32  frames delivered; wraps at 2^32.
- err_count  out  ERR_CNT_WIDTH  framing errors; saturates at all-ones.

Behaviour:
- Reset (asynchronous, all state):
  - State is IDLE, the word index is 0, and the mode latch is 0.
  - All outputs are 0, except s_axis_ready = 1.
  - Assertion mid-frame discards the partial frame with no error pulse.
- Word acceptance: a word is accepted on a cycle with s_axis_valid & s_axis_ready. N = HDR_WORDS + PAY_WORDS when the mode latch is 0, and PAY_WORDS when it is 1.
- Field loading: each accepted word shifts into its field register, field <= {field[W-33:0], s_axis_data}.
  - Encryption: index 0-7 go to key, 8-9 to nonce, 10-11 to counter, 12-27 to payload.
  - Decryption: index 0-15 go to payload; key, nonce and counter are cleared at frame start.
- IDLE: s_axis_ready = 1. The first accepted word latches encryp_decryp, loads index 0, and moves to RECV. If that word also carries last, it is handled as an early last.
- RECV: s_axis_ready = 1, and the index increments per accepted word.
  - Last on index N-1: move to HOLD.
  - Last before index N-1: frame_err pulses the next cycle, err_count increments, the partial frame is discarded, and the state returns to IDLE.
  - Index N-1 accepted without last: frame_err pulses, err_count increments, and the state moves to DRAIN.
- DRAIN: s_axis_ready = 1. Accepted words are discarded until a word with last is accepted, then the state returns to IDLE. No further error pulses occur while draining.
- HOLD:
  - s_axis_ready = 0.
  - frame_valid = 1 starting the cycle after the last word is accepted (latency 1).
  - All frame_* outputs are stable while frame_valid is high.
  - On frame_valid & frame_ready: good_count increments, and frame_valid and the state return to IDLE on the next edge. s_axis_ready reasserts that same cycle, so there is one bubble per frame.
- Output registers: frame_* outputs update only on entry to HOLD, never during RECV.
- Mode changes: an encryp_decryp change mid-frame is ignored until the next IDLE.
- Simultaneous events: a framing error and a frame_ready handshake cannot coincide, because HOLD blocks input.
- Counter limits: good_count wraps from 0xFFFFFFFF to 0. err_count holds at all-ones.

Test Plan:
- Encryption frame: encryp_decryp=0, 28 words 0x00000001..0x0000001C, last on word 28, frame_ready=1 → one cycle later frame_valid=1, frame_key=0x00000001_..._00000008, frame_nonce=0x00000009_0000000A, frame_counter=0x0000000B_0000000C, frame_data MSW=0x0000000D, LSW=0x0000001C; good_count=1.
- Decryption frame: encryp_decryp=1, 16 words 0xA0000000+i → frame_data MSW=0xA0000000, LSW=0xA000000F, key/nonce/counter=0, frame_valid 1 cycle after last.
- Backpressure: frame_ready held 0 for 10 cycles after frame_valid → s_axis_ready=0 and outputs stable throughout. Raise frame_ready → ready returns, and the next frame is received correctly.
- Early last: encryption mode, last on word 5 → frame_err pulses 1 cycle, err_count=1, no frame_valid, and the next good frame is delivered intact.
- Missing last: decryption mode, 20 words with last on word 20 → frame_err once after word 16, words 17-20 drained, no frame_valid, then a good frame follows.
- Reset mid-frame: assert axis_reset_n=0 after word 10 → all outputs 0 immediately, s_axis_ready=1, counters 0, and the next frame is received correctly.

Source files
------------

// File: rtl/axis_frame_receiver.sv
// AXI4-Stream slave that reassembles crypto-engine output words into key/nonce/counter/payload
// fields, validates framing against the selected mode, and holds each good frame until consumed.
module axis_frame_receiver #(
  parameter int HDR_WORDS     = 12,
  parameter int PAY_WORDS     = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     axis_clk,
  input  logic                     axis_reset_n,
  input  logic                     encryp_decryp,
  input  logic                     s_axis_valid,
  input  logic [31:0]              s_axis_data,
  input  logic                     s_axis_last,
  output logic                     s_axis_ready,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [255:0]             frame_key,
  output logic [63:0]              frame_nonce,
  output logic [63:0]              frame_counter,
  output logic [PAY_WORDS*32-1:0]  frame_data,
  output logic                     frame_err,
  output logic [31:0]              good_count,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam int FRM_WORDS = HDR_WORDS + PAY_WORDS;
  localparam int IDX_W     = $clog2(FRM_WORDS + 1);
  localparam int PW        = PAY_WORDS * 32;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, word_idx, last_idx;
  logic             mode, cur_mode, accept, load_word, to_hold, err_nxt;
  logic             in_key, in_nonce, in_ctr;
  logic [255:0]     key_sh;
  logic [63:0]      nonce_sh, ctr_sh;
  // Payload shadow holds all but the final word; the final word is merged on entry to HOLD.
  logic [PW-33:0]   pay_sh;

  assign s_axis_ready = (state != HOLD);
  assign frame_valid  = (state == HOLD);
  assign accept       = s_axis_valid & s_axis_ready;
  assign load_word    = accept & ((state == IDLE) | (state == RECV));
  assign cur_mode     = (state == IDLE) ? encryp_decryp : mode;
  assign word_idx     = (state == IDLE) ? '0 : idx;
  assign last_idx     = cur_mode ? IDX_W'(PAY_WORDS - 1) : IDX_W'(FRM_WORDS - 1);
  assign in_key       = !cur_mode && (word_idx < IDX_W'(8));
  assign in_nonce     = !cur_mode && (word_idx >= IDX_W'(8))  && (word_idx < IDX_W'(10));
  assign in_ctr       = !cur_mode && (word_idx >= IDX_W'(10)) && (word_idx < IDX_W'(12));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    to_hold   = 1'b0;
    case (state)
      IDLE, RECV: if (accept) begin
        idx_nxt   = word_idx + 1'b1;
        state_nxt = RECV;
        if (word_idx == last_idx) begin
          if (s_axis_last) begin
            state_nxt = HOLD;
            to_hold   = 1'b1;
          end else begin
            state_nxt = DRAIN;
            err_nxt   = 1'b1;
          end
        end else if (s_axis_last) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      DRAIN:   if (accept && s_axis_last) state_nxt = IDLE;
      HOLD:    if (frame_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      state <= IDLE;
      idx   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (accept && state == IDLE) mode <= encryp_decryp;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      key_sh   <= '0;
      nonce_sh <= '0;
      ctr_sh   <= '0;
      pay_sh   <= '0;
    end else if (load_word) begin
      if (word_idx == '0) begin
        key_sh   <= '0;
        nonce_sh <= '0;
        ctr_sh   <= '0;
      end
      if (in_key)        key_sh   <= {key_sh[223:0], s_axis_data};
      else if (in_nonce) nonce_sh <= {nonce_sh[31:0], s_axis_data};
      else if (in_ctr)   ctr_sh   <= {ctr_sh[31:0], s_axis_data};
      else               pay_sh   <= {pay_sh[PW-65:0], s_axis_data};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      frame_key     <= '0;
      frame_nonce   <= '0;
      frame_counter <= '0;
      frame_data    <= '0;
      frame_err     <= 1'b0;
      good_count    <= '0;
      err_count     <= '0;
    end else begin
      frame_err <= err_nxt;
      if (to_hold) begin
        frame_key     <= key_sh;
        frame_nonce   <= nonce_sh;
        frame_counter <= ctr_sh;
        frame_data    <= {pay_sh, s_axis_data};
      end
      if (frame_valid && frame_ready) good_count <= good_count + 32'd1;
      if (err_nxt && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_frame_receiver.sv
// Scoreboard bench: stimulus pushes expected frames built from word lists; a monitor pops on handshake.
module tb_axis_frame_receiver;
  logic         axis_clk = 1'b0;
  logic         axis_reset_n = 1'b0;
  logic         encryp_decryp = 1'b0;
  logic         s_axis_valid = 1'b0;
  logic [31:0]  s_axis_data = '0;
  logic         s_axis_last = 1'b0;
  logic         s_axis_ready;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic [255:0] frame_key;
  logic [63:0]  frame_nonce, frame_counter;
  logic [511:0] frame_data;
  logic         frame_err;
  logic [31:0]  good_count;
  logic [7:0]   err_count;

  axis_frame_receiver #(.HDR_WORDS(12), .PAY_WORDS(16), .ERR_CNT_WIDTH(8)) dut (
    .axis_clk(axis_clk), .axis_reset_n(axis_reset_n), .encryp_decryp(encryp_decryp),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_ready(s_axis_ready), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_key(frame_key), .frame_nonce(frame_nonce), .frame_counter(frame_counter),
    .frame_data(frame_data), .frame_err(frame_err), .good_count(good_count),
    .err_count(err_count)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [255:0] key;
    logic [63:0]  nonce;
    logic [63:0]  ctr;
    logic [511:0] data;
  } frm_t;

  frm_t exp_q[$];
  int errors = 0, checks = 0;
  int exp_good = 0, exp_err = 0, err_pulses = 0;
  int rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Consumer-side ready, changed just after the clock edge.
  initial forever begin
    @(posedge axis_clk);
    #1;
    case (rdy_mode)
      0:       frame_ready = ($urandom_range(0, 3) != 0);
      1:       frame_ready = 1'b0;
      default: frame_ready = 1'b1;
    endcase
  end

  // Monitor: error pulse count, output stability while held, scoreboard pop on handshake.
  initial begin
    frm_t e, h;
    logic held;
    held = 1'b0;
    forever begin
      @(negedge axis_clk);
      if (!axis_reset_n) begin
        held = 1'b0;
        continue;
      end
      if (frame_err) err_pulses++;
      if (frame_valid) begin
        if (held) begin
          check("stable_key", frame_key, h.key);
          check("stable_nonce", frame_nonce, h.nonce);
          check("stable_counter", frame_counter, h.ctr);
          check("stable_data", frame_data, h.data);
        end
        h.key = frame_key; h.nonce = frame_nonce; h.ctr = frame_counter; h.data = frame_data;
        held = 1'b1;
        if (frame_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame got=frame_valid exp=none");
          end else begin
            e = exp_q.pop_front();
            check("frame_key", frame_key, e.key);
            check("frame_nonce", frame_nonce, e.nonce);
            check("frame_counter", frame_counter, e.ctr);
            check("frame_data", frame_data, e.data);
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic l, input logic md);
    int t;
    t = 0;
    repeat ($urandom_range(0, 1)) @(negedge axis_clk);
    s_axis_valid = 1'b1; s_axis_data = d; s_axis_last = l; encryp_decryp = md;
    while (!s_axis_ready && t < 300) begin
      @(negedge axis_clk);
      t++;
    end
    if (!s_axis_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    @(posedge axis_clk);
    @(negedge axis_clk);
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic send_frame(input logic mode, input int len, input logic rnd, input logic [31:0] base);
    logic [31:0] w[$];
    frm_t e;
    int n;
    n = mode ? 16 : 28;
    for (int i = 0; i < len; i++) w.push_back(rnd ? $urandom : base + i);
    if (len == n) begin
      e.key = '0; e.nonce = '0; e.ctr = '0; e.data = '0;
      if (!mode) begin
        for (int i = 0; i < 8; i++)  e.key[255-32*i -: 32] = w[i];
        for (int i = 0; i < 2; i++)  e.nonce[63-32*i -: 32] = w[8+i];
        for (int i = 0; i < 2; i++)  e.ctr[63-32*i -: 32]   = w[10+i];
        for (int i = 0; i < 16; i++) e.data[511-32*i -: 32] = w[12+i];
      end else begin
        for (int i = 0; i < 16; i++) e.data[511-32*i -: 32] = w[i];
      end
      exp_q.push_back(e);
      exp_good++;
    end
    for (int k = 0; k < len; k++) begin
      send_word(w[k], k == len - 1, (k == 0) ? mode : 1'($urandom_range(0, 1)));
      if (len == n && k == n - 1) begin
        check("valid_latency", frame_valid, 1);
      end else if (len < n && k == len - 1) begin
        exp_err++;
        check("early_err_pulse", frame_err, 1);
        check("early_no_valid", frame_valid, 0);
      end else if (len > n && k == n - 1) begin
        exp_err++;
        check("missing_err_pulse", frame_err, 1);
        check("missing_no_valid", frame_valid, 0);
      end else begin
        check("no_err_pulse", frame_err, 0);
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (frame_valid && t < 200) begin
      @(negedge axis_clk);
      t++;
    end
    if (frame_valid) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout got=frame_valid exp=released");
    end
  endtask

  task automatic check_reset_state();
    check("rst_ready", s_axis_ready, 1);
    check("rst_valid", frame_valid, 0);
    check("rst_key", frame_key, 0);
    check("rst_nonce", frame_nonce, 0);
    check("rst_counter", frame_counter, 0);
    check("rst_data", frame_data, 0);
    check("rst_err", frame_err, 0);
    check("rst_good", good_count, 0);
    check("rst_errcnt", err_count, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, kind, n, len;
    repeat (2) @(negedge axis_clk);
    check_reset_state();
    axis_reset_n = 1'b1;
    @(negedge axis_clk);

    // Directed encryption and decryption frames.
    rdy_mode = 2;
    send_frame(1'b0, 28, 1'b0, 32'h1);
    wait_idle();
    check("good_after_enc", good_count, 32'(exp_good));
    send_frame(1'b1, 16, 1'b0, 32'hA000_0000);
    wait_idle();
    check("good_after_dec", good_count, 32'(exp_good));

    // Backpressure.
    rdy_mode = 1;
    send_frame(1'b0, 28, 1'b1, 32'h0);
    repeat (10) begin
      @(negedge axis_clk);
      check("bp_ready_low", s_axis_ready, 0);
      check("bp_valid_high", frame_valid, 1);
    end
    rdy_mode = 2;
    wait_idle();
    check("ready_returns", s_axis_ready, 1);
    send_frame(1'b1, 16, 1'b1, 32'h0);
    wait_idle();

    // Early last, then a good frame.
    send_frame(1'b0, 5, 1'b1, 32'h0);
    check("errcnt_early", err_count, 8'(exp_err));
    send_frame(1'b0, 28, 1'b1, 32'h0);
    wait_idle();

    // Missing last with drain, then a good frame.
    send_frame(1'b1, 20, 1'b1, 32'h0);
    check("errcnt_missing", err_count, 8'(exp_err));
    send_frame(1'b1, 16, 1'b1, 32'h0);
    wait_idle();
    check("good_before_reset", good_count, 32'(exp_good));

    // Reset in the middle of a frame.
    for (int i = 0; i < 10; i++) send_word(32'h5000_0000 + i, 1'b0, 1'b0);
    axis_reset_n = 1'b0;
    #1;
    check_reset_state();
    exp_good = 0; exp_err = 0; err_pulses = 0;
    @(negedge axis_clk);
    axis_reset_n = 1'b1;
    @(negedge axis_clk);
    send_frame(1'b0, 28, 1'b1, 32'h0);
    wait_idle();
    check("good_after_reset", good_count, 32'(exp_good));

    // Randomized mix.
    rdy_mode = 0;
    repeat (40) begin
      mode = $urandom_range(0, 1);
      n    = mode ? 16 : 28;
      kind = $urandom_range(0, 5);
      if (kind <= 3)      len = n;
      else if (kind == 4) len = $urandom_range(1, n - 1);
      else                len = $urandom_range(n + 1, n + 4);
      send_frame(1'(mode), len, 1'b1, 32'h0);
    end
    wait_idle();
    repeat (3) @(negedge axis_clk);
    check("final_good", good_count, 32'(exp_good));
    check("final_errcnt", err_count, 8'((exp_err > 255) ? 255 : exp_err));
    check("final_err_pulses", 32'(err_pulses), 32'(exp_err));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
